// File: rtl/pre_norm_mul_pipe.sv
// Pipelined FP32 multiply front end: unpack, sign, biased exponent sum with class, 48-bit
// mantissa product, valid/ready on both sides. Define MUL_NAN_INF_EN to build inf/nan flags.
`timescale 1ns/1ps
module pre_norm_mul_pipe #(
   parameter int PIPE_STAGES = 3
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic [1:0]  rmode_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] opa_o,
   output logic [31:0] opb_o,
   output logic [1:0]  rmode_o,
   output logic        sign_o,
   output logic [7:0]  exp_10_o,
   output logic [1:0]  exp_ovf_o,
   output logic [47:0] fract_48_o,
   output logic        inf_o,
   output logic        nan_o
);
   localparam int N   = PIPE_STAGES;
   localparam int SBW = 77;

   logic [7:0]     ea_s, eb_s, ea_eff_s, eb_eff_s;
   logic [23:0]    ma_s, mb_s;
   logic [9:0]     s_s;
   logic [1:0]     ovf_s;
   logic [SBW-1:0] sb_in_s;
   logic           adv_s;
   logic [N:1]     vld_d, vld_q;
   logic [SBW-1:0] sb_d [1:N];
   logic [SBW-1:0] sb_q [1:N];
   logic [23:0]    ma_d, ma_q, mb_d, mb_q;
   logic [47:0]    fract_s;

   // Whole pipe advances together; a stalled output freezes every stage.
   assign adv_s      = !vld_q[N] | out_ready_i;
   assign in_ready_o = adv_s;

   // Unpack operands; S is kept 10-bit signed so the class compares see the true sum.
   always_comb begin
      ea_s     = opa_i[30:23];
      eb_s     = opb_i[30:23];
      ea_eff_s = (ea_s == 8'd0) ? 8'd1 : ea_s;
      eb_eff_s = (eb_s == 8'd0) ? 8'd1 : eb_s;
      ma_s     = {(ea_s != 8'd0), opa_i[22:0]};
      mb_s     = {(eb_s != 8'd0), opb_i[22:0]};
      s_s      = {2'b00, ea_eff_s} + {2'b00, eb_eff_s} - 10'd127;
      if ($signed(s_s) >= 10'sd255) begin
         ovf_s = 2'b11;
      end else if ($signed(s_s) <= 10'sd0) begin
         ovf_s = 2'b10;
      end else if (s_s == 10'd254) begin
         ovf_s = 2'b01;
      end else begin
         ovf_s = 2'b00;
      end
      sb_in_s = {opa_i, opb_i, rmode_i, opa_i[31] ^ opb_i[31], s_s[7:0], ovf_s};
   end

   // Valid bits and sideband shift one stage per advance, bubbles included.
   always_comb begin
      vld_d = vld_q;
      ma_d  = ma_q;
      mb_d  = mb_q;
      for (int i = 1; i <= N; i++) begin
         sb_d[i] = sb_q[i];
      end
      if (adv_s) begin
         vld_d   = {vld_q[N-1:1], in_valid_i};
         sb_d[1] = sb_in_s;
         for (int i = 2; i <= N; i++) begin
            sb_d[i] = sb_q[i-1];
         end
         ma_d = ma_s;
         mb_d = mb_s;
      end else begin
         vld_d = vld_q;
      end
   end

   // Stage registers for valid, sideband and unpacked mantissas.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld_q <= {N{1'b0}};
         ma_q  <= 24'd0;
         mb_q  <= 24'd0;
         for (int i = 1; i <= N; i++) begin
            sb_q[i] <= {SBW{1'b0}};
         end
      end else begin
         vld_q <= vld_d;
         ma_q  <= ma_d;
         mb_q  <= mb_d;
         for (int i = 1; i <= N; i++) begin
            sb_q[i] <= sb_d[i];
         end
      end
   end

   generate
      if (N == 2) begin : g_mul2
         logic [47:0] fract_d, fract_q;

         // Short pipe: whole 24x24 product in one stage.
         always_comb begin
            if (adv_s) begin
               fract_d = {24'd0, ma_q} * {24'd0, mb_q};
            end else begin
               fract_d = fract_q;
            end
         end

         // Product register.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               fract_q <= 48'd0;
            end else begin
               fract_q <= fract_d;
            end
         end

         assign fract_s = fract_q;
      end else begin : g_mul34
         logic [35:0] pp_lo_d, pp_lo_q, pp_hi_d, pp_hi_q;
         logic [47:0] f3_d, f3_q;

         // Two 24x12 partial products, then one aligned add in the next stage.
         always_comb begin
            if (adv_s) begin
               pp_lo_d = {12'd0, ma_q} * {24'd0, mb_q[11:0]};
               pp_hi_d = {12'd0, ma_q} * {24'd0, mb_q[23:12]};
               f3_d    = {12'd0, pp_lo_q} + {pp_hi_q, 12'd0};
            end else begin
               pp_lo_d = pp_lo_q;
               pp_hi_d = pp_hi_q;
               f3_d    = f3_q;
            end
         end

         // Partial-product and sum registers.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               pp_lo_q <= 36'd0;
               pp_hi_q <= 36'd0;
               f3_q    <= 48'd0;
            end else begin
               pp_lo_q <= pp_lo_d;
               pp_hi_q <= pp_hi_d;
               f3_q    <= f3_d;
            end
         end

         if (N == 4) begin : g_out4
            logic [47:0] f4_d, f4_q;

            // Extra retiming stage for the four-deep configuration.
            always_comb begin
               if (adv_s) begin
                  f4_d = f3_q;
               end else begin
                  f4_d = f4_q;
               end
            end

            // Output product register.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
               if (!rst_n_i) begin
                  f4_q <= 48'd0;
               end else begin
                  f4_q <= f4_d;
               end
            end

            assign fract_s = f4_q;
         end else begin : g_out3
            assign fract_s = f3_q;
         end
      end
   endgenerate

   assign out_valid_o = vld_q[N];
   assign {opa_o, opb_o, rmode_o, sign_o, exp_10_o, exp_ovf_o} = sb_q[N];
   assign fract_48_o  = fract_s;

`ifdef MUL_NAN_INF_EN
   logic       a_inf_s, b_inf_s, a_nan_s, b_nan_s, a_zero_s, b_zero_s;
   logic [1:0] flg_in_s;
   logic [1:0] flg_d [1:N];
   logic [1:0] flg_q [1:N];

   // Special-operand detection; inf x zero is invalid and reported as NaN.
   always_comb begin
      a_inf_s  = (opa_i[30:23] == 8'hFF) && (opa_i[22:0] == 23'd0);
      b_inf_s  = (opb_i[30:23] == 8'hFF) && (opb_i[22:0] == 23'd0);
      a_nan_s  = (opa_i[30:23] == 8'hFF) && (opa_i[22:0] != 23'd0);
      b_nan_s  = (opb_i[30:23] == 8'hFF) && (opb_i[22:0] != 23'd0);
      a_zero_s = (opa_i[30:0] == 31'd0);
      b_zero_s = (opb_i[30:0] == 31'd0);
      flg_in_s[0] = a_nan_s | b_nan_s | (a_inf_s & b_zero_s) | (b_inf_s & a_zero_s);
      flg_in_s[1] = (a_inf_s | b_inf_s) & !flg_in_s[0];
   end

   // Flags ride the same shift schedule as the sideband.
   always_comb begin
      for (int i = 1; i <= N; i++) begin
         flg_d[i] = flg_q[i];
      end
      if (adv_s) begin
         flg_d[1] = flg_in_s;
         for (int i = 2; i <= N; i++) begin
            flg_d[i] = flg_q[i-1];
         end
      end else begin
         flg_d[1] = flg_q[1];
      end
   end

   // Flag stage registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 1; i <= N; i++) begin
            flg_q[i] <= 2'b00;
         end
      end else begin
         for (int i = 1; i <= N; i++) begin
            flg_q[i] <= flg_d[i];
         end
      end
   end

   assign inf_o = flg_q[N][1];
   assign nan_o = flg_q[N][0];
`else
   assign inf_o = 1'b0;
   assign nan_o = 1'b0;
`endif

endmodule

// File: tb/tb_pre_norm_mul_pipe.sv
// Self-checking bench for pre_norm_mul_pipe: directed vectors, stalls, mid-flight reset and
// randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pre_norm_mul_pipe;
   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] opa_i, opb_i;
   logic [1:0]  rmode_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] opa_o, opb_o;
   logic [1:0]  rmode_o;
   logic        sign_o;
   logic [7:0]  exp_10_o;
   logic [1:0]  exp_ovf_o;
   logic [47:0] fract_48_o;
   logic        inf_o, nan_o;

   typedef struct packed {
      logic [31:0] opa;
      logic [31:0] opb;
      logic [1:0]  rmode;
      logic        sign;
      logic [7:0]  exp10;
      logic [1:0]  ovf;
      logic [47:0] fract;
      logic        inf;
      logic        nan;
   } res_t;

   res_t exp_q[$];
   res_t obs_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pre_norm_mul_pipe #(.PIPE_STAGES(3)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .opa_i(opa_i), .opb_i(opb_i), .rmode_i(rmode_i), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .opa_o(opa_o), .opb_o(opb_o), .rmode_o(rmode_o),
      .sign_o(sign_o), .exp_10_o(exp_10_o), .exp_ovf_o(exp_ovf_o), .fract_48_o(fract_48_o),
      .inf_o(inf_o), .nan_o(nan_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
      res_t   r;
      int     ea, eb, s;
      longint ma, mb;
`ifdef MUL_NAN_INF_EN
      bit a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
`endif
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = longint'(a[22:0]) + ((ea != 0) ? 8388608 : 0);
      mb = longint'(b[22:0]) + ((eb != 0) ? 8388608 : 0);
      s  = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 127;
      r.opa   = a;
      r.opb   = b;
      r.rmode = rm;
      r.sign  = a[31] ^ b[31];
      r.exp10 = 8'(s & 255);
      if (s >= 255)      r.ovf = 2'b11;
      else if (s <= 0)   r.ovf = 2'b10;
      else if (s == 254) r.ovf = 2'b01;
      else               r.ovf = 2'b00;
      r.fract = 48'(ma * mb);
      r.inf   = 1'b0;
      r.nan   = 1'b0;
`ifdef MUL_NAN_INF_EN
      a_inf  = (ea == 255) && (a[22:0] == 23'd0);
      b_inf  = (eb == 255) && (b[22:0] == 23'd0);
      a_nan  = (ea == 255) && (a[22:0] != 23'd0);
      b_nan  = (eb == 255) && (b[22:0] != 23'd0);
      a_zero = (a[30:0] == 31'd0);
      b_zero = (b[30:0] == 31'd0);
      r.nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      r.inf  = (a_inf || b_inf) && !r.nan;
`endif
      return r;
   endfunction

   function automatic res_t cur_out();
      return {opa_o, opb_o, rmode_o, sign_o, exp_10_o, exp_ovf_o, fract_48_o, inf_o, nan_o};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] f;
      int          k;
      k = $urandom_range(0, 7);
      case (k)
         0: e = 8'd0;
         1: e = 8'd1;
         2: e = 8'd127;
         3: e = 8'd254;
         4: e = 8'd255;
         default: e = 8'($urandom_range(0, 255));
      endcase
      f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
      return {1'($urandom), e, f};
   endfunction

   // Handshake collector: records accepted beats (as model results) and emitted results.
   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (in_valid_i && in_ready_o) exp_q.push_back(model(opa_i, opb_i, rmode_i));
         if (out_valid_o && out_ready_i) obs_q.push_back(cur_out());
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      opa_i = 32'd0; opb_i = 32'd0; rmode_i = 2'b00;
      tick(); tick();
      n_checks++;
      if (out_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid_o);
      end
      n_checks++;
      if (cur_out() !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h expected 0", cur_out());
      end
      n_checks++;
      if (in_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready_o);
      end
      rst_n_i = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      int   cyc;
      res_t want;
      out_ready_i = 1'b1;
      opa_i = 32'h3FC00000; opb_i = 32'h40000000; rmode_i = 2'b10; in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      cyc = 1;
      while (!out_valid_o && cyc < 20) begin
         tick(); cyc++;
      end
      n_checks++;
      if (cyc !== 3) begin
         n_fail++; $display("FAIL latency: got %0d cycles expected 3", cyc);
      end
      want = {32'h3FC00000, 32'h40000000, 2'b10, 1'b0, 8'h80, 2'b00, 48'h6000_0000_0000, 1'b0, 1'b0};
      n_checks++;
      if (cur_out() !== want) begin
         n_fail++; $display("FAIL vec1_fields: got %h expected %h", cur_out(), want);
      end
      tick();
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_directed();
      logic [31:0] ta [10] = '{32'h3FC00000, 32'h7F000000, 32'hC0000000, 32'h00800000, 32'h00000001,
                               32'h00000000, 32'h7F800000, 32'h7F800000, 32'h7F000000, 32'h00800000};
      logic [31:0] tb [10] = '{32'h40000000, 32'h7F000000, 32'h40000000, 32'h00800000, 32'h3F800000,
                               32'h3F800000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F000000};
      logic [7:0]  te [10] = '{8'h80, 8'h7D, 8'h81, 8'h83, 8'h01, 8'h01, 8'h81, 8'hFF, 8'hFE, 8'h00};
      logic [1:0]  tv [10] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10};
      logic        ts [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [47:0] tf [10] = '{48'h6000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
                               48'h4000_0000_0000, 48'h0000_0080_0000, 48'h0, 48'h0,
                               48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000};
      logic        ti [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic        tn [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      res_t        want;
      int          cyc;
      out_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         opa_i = ta[i]; opb_i = tb[i]; rmode_i = 2'(i); in_valid_i = 1'b1;
         tick();
      end
      in_valid_i = 1'b0;
      cyc = 0;
      while (obs_q.size() < 10 && cyc < 50) begin
         tick(); cyc++;
      end
      n_checks++;
      if (obs_q.size() !== 10) begin
         n_fail++; $display("FAIL directed_count: got %0d expected 10", obs_q.size());
      end
      for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
`ifdef MUL_NAN_INF_EN
         want = {ta[i], tb[i], 2'(i), ts[i], te[i], tv[i], tf[i], ti[i], tn[i]};
`else
         want = {ta[i], tb[i], 2'(i), ts[i], te[i], tv[i], tf[i], 1'b0, 1'b0};
`endif
         n_checks++;
         if (obs_q[i] !== want) begin
            n_fail++; $display("FAIL directed_vec%0d: got %h expected %h", i, obs_q[i], want);
         end
         n_checks++;
         if (i < exp_q.size() && obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL directed_model%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back();
      res_t snap;
      int   cyc;
      out_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         opa_i = rand_op(); opb_i = rand_op(); rmode_i = 2'($urandom); in_valid_i = 1'b1;
         tick();
      end
      opa_i = rand_op(); opb_i = rand_op(); rmode_i = 2'($urandom);
      snap = cur_out();
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready%0d: got %b expected 0", k, in_ready_o);
         end
         n_checks++;
         if (out_valid_o !== 1'b1 || cur_out() !== snap) begin
            n_fail++; $display("FAIL stall_hold%0d: got v=%b %h expected v=1 %h", k, out_valid_o, cur_out(), snap);
         end
         tick();
      end
      out_ready_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      cyc = 0;
      while (obs_q.size() < 4 && cyc < 50) begin
         tick(); cyc++;
      end
      repeat (3) tick();
      n_checks++;
      if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
         n_fail++; $display("FAIL stall_count: got %0d/%0d expected 4/4", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL stall_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      int cyc;
      cyc = 0;
      while (exp_q.size() < 200 && cyc < 5000) begin
         opa_i = rand_op(); opb_i = rand_op(); rmode_i = 2'($urandom);
         in_valid_i  = ($urandom_range(0, 9) < 7);
         out_ready_i = ($urandom_range(0, 9) < 7);
         tick(); cyc++;
      end
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      cyc = 0;
      while (obs_q.size() < exp_q.size() && cyc < 50) begin
         tick(); cyc++;
      end
      n_checks++;
      if (obs_q.size() !== exp_q.size() || exp_q.size() < 200) begin
         n_fail++; $display("FAIL random_count: got %0d results for %0d beats", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL random_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_midflight();
      int cyc;
      out_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         opa_i = rand_op(); opb_i = rand_op(); rmode_i = 2'($urandom); in_valid_i = 1'b1;
         tick();
      end
      in_valid_i = 1'b0;
      tick();
      n_checks++;
      if (out_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid_o);
      end
      rst_n_i = 1'b0;
      #1;
      n_checks++;
      if (out_valid_o !== 1'b0 || cur_out() !== '0) begin
         n_fail++; $display("FAIL rst_async: got v=%b %h expected v=0 0", out_valid_o, cur_out());
      end
      exp_q.delete(); obs_q.delete();
      tick();
      rst_n_i = 1'b1; out_ready_i = 1'b1;
      repeat (10) tick();
      n_checks++;
      if (obs_q.size() !== 0) begin
         n_fail++; $display("FAIL rst_discard: got %0d results expected 0", obs_q.size());
      end
      opa_i = rand_op(); opb_i = rand_op(); rmode_i = 2'($urandom); in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
      cyc = 1;
      while (!out_valid_o && cyc < 20) begin
         tick(); cyc++;
      end
      n_checks++;
      if (cyc !== 3) begin
         n_fail++; $display("FAIL rst_latency: got %0d cycles expected 3", cyc);
      end
      tick();
      n_checks++;
      if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
         n_fail++; $display("FAIL rst_next_beat: got %0d results expected 1 matching model", obs_q.size());
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
